// File: rtl/decode_hazard_ctrl.sv
// Decode-stage sequencer: IF/ID register, load-use bubble insertion and branch flush handling.
// Optional performance counters are enabled by defining DECODE_PERF_CNT_EN.
module decode_hazard_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_ready,
    output logic            id_valid,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    input  logic            id_ready,
    input  logic            ex_valid,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_rd,
    input  logic            flush_req,
    output logic            lu_stall
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {S_RUN, S_LU_STALL, S_FLUSH} state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);
    localparam state_t     FLUSH_DEST = (FLUSH_CYCLES > 0) ? S_FLUSH : S_RUN;

    state_t            state_q, state_d;
    logic              reg_valid_q, reg_valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [3:0]        cnt_q, cnt_d;

    logic use_rs1, use_rs2, hazard, load;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (instr_q[6:0])
            OPC_OP, OPC_STORE, OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: use_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign hazard = reg_valid_q & ex_valid & ex_is_load & (ex_rd != 5'd0)
                  & ((use_rs1 & (instr_q[19:15] == ex_rd))
                   | (use_rs2 & (instr_q[24:20] == ex_rd)));

    always_comb begin
        state_d     = state_q;
        reg_valid_d = reg_valid_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        load        = 1'b0;
        id_valid    = 1'b0;
        lu_stall    = 1'b0;
        if_ready    = 1'b0;

        case (state_q)
            S_RUN: begin
                id_valid = reg_valid_q & ~hazard;
                lu_stall = hazard & id_ready;
                load     = ~reg_valid_q | (id_ready & ~hazard);
                if (hazard && id_ready) state_d = S_LU_STALL;
            end
            S_LU_STALL: begin
                // The load has moved past EX, so the held instruction may issue.
                id_valid = reg_valid_q;
                load     = ~reg_valid_q | id_ready;
                if (id_ready) state_d = S_RUN;
            end
            S_FLUSH: begin
                reg_valid_d = 1'b0;
                if (if_valid) begin
                    if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase

        if_ready = load | (state_q == S_FLUSH);

        if (load) begin
            reg_valid_d = if_valid;
            if (if_valid) begin
                instr_d = if_instr;
                pc_d    = if_pc;
            end
        end

        // A flush squashes decode and drops whatever fetch presents this cycle.
        if (flush_req) begin
            reg_valid_d = 1'b0;
            instr_d     = instr_q;
            pc_d        = pc_q;
            lu_stall    = 1'b0;
            cnt_d       = FLUSH_INIT;
            state_d     = FLUSH_DEST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            reg_valid_q <= 1'b0;
            instr_q     <= 32'h0000_0013;
            pc_q        <= '0;
            cnt_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            reg_valid_q <= reg_valid_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign id_instr = instr_q;
    assign id_pc    = pc_q;

`ifdef DECODE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(lu_stall);
        flush_cnt_d = flush_cnt_q + CNT_W'(flush_req);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
`endif

endmodule
